wptr_full_prog: RTL

Write-clock-domain pointer and status block for the asynchronous FIFO. It keeps the dual binary/Gray write pointer and registered full detection. It also adds an internal read-pointer synchronizer of configurable depth, a registered fill level, a programmable almost-full flag and a sticky overflow error flag. It sits between the write-side client and the dual-port FIFO memory, and takes the raw Gray read pointer straight from the read-clock domain.

---
 rtl/wptr_full_prog.sv | 112 +++++++++++
 1 files changed

// File: rtl/wptr_full_prog.sv
// Write-domain pointer/status block for an async FIFO: binary/Gray write pointer,
// read-pointer synchronizer, registered full, fill level, almost-full and sticky overflow.
module wptr_full_prog #(
  parameter int ADDRSIZE    = 9,
  parameter int SYNC_STAGES = 2
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   rptr,
  input  logic [ADDRSIZE:0]   af_thresh,
  input  logic                wovf_clr,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE:0]   wptr,
  output logic                wfull,
  output logic                walmost_full,
  output logic [ADDRSIZE:0]   wlevel,
  output logic                wovf
);

  function automatic logic [ADDRSIZE:0] bin2gray(input logic [ADDRSIZE:0] b);
    return (b >> 1) ^ b;
  endfunction

  function automatic logic [ADDRSIZE:0] gray2bin(input logic [ADDRSIZE:0] g);
    logic [ADDRSIZE:0] b;
    b = g;
    for (int i = ADDRSIZE - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [ADDRSIZE:0] sync_r [SYNC_STAGES];
  logic [ADDRSIZE:0] wbin_r;
  logic [ADDRSIZE:0] wptr_r;
  logic [ADDRSIZE:0] wlevel_r;
  logic              wfull_r;
  logic              walmost_full_r;
  logic              wovf_r;

  logic [ADDRSIZE:0] wq_rptr_s;
  logic [ADDRSIZE:0] wq_rbin_s;
  logic              winc_ok_s;
  logic [ADDRSIZE:0] wbinnext_s;
  logic [ADDRSIZE:0] wgraynext_s;
  logic [ADDRSIZE:0] wlevel_next_s;
  logic              wfull_next_s;
  logic              walmost_full_next_s;
  logic              wovf_next_s;

  // Multi-flop synchronizer bringing the Gray read pointer into wclk
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_r[i] <= '0;
      end
    end else begin
      sync_r[0] <= rptr;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
    end
  end

  // Next-state pointer, status and overflow computation
  always_comb begin
    wq_rptr_s     = sync_r[SYNC_STAGES-1];
    wq_rbin_s     = gray2bin(wq_rptr_s);
    winc_ok_s     = winc & ~wfull_r;
    wbinnext_s    = wbin_r + {{ADDRSIZE{1'b0}}, winc_ok_s};
    wgraynext_s   = bin2gray(wbinnext_s);
    // Full when the next write pointer equals the read pointer with its top two Gray bits inverted
    wfull_next_s  = (wgraynext_s == {~wq_rptr_s[ADDRSIZE:ADDRSIZE-1], wq_rptr_s[ADDRSIZE-2:0]});
    wlevel_next_s = wbinnext_s - wq_rbin_s;
    walmost_full_next_s = (wlevel_next_s >= af_thresh);
    if (winc && wfull_r) begin
      wovf_next_s = 1'b1;
    end else if (wovf_clr) begin
      wovf_next_s = 1'b0;
    end else begin
      wovf_next_s = wovf_r;
    end
  end

  // Pointer and status registers
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin_r         <= '0;
      wptr_r         <= '0;
      wlevel_r       <= '0;
      wfull_r        <= 1'b0;
      walmost_full_r <= 1'b0;
      wovf_r         <= 1'b0;
    end else begin
      wbin_r         <= wbinnext_s;
      wptr_r         <= wgraynext_s;
      wlevel_r       <= wlevel_next_s;
      wfull_r        <= wfull_next_s;
      walmost_full_r <= walmost_full_next_s;
      wovf_r         <= wovf_next_s;
    end
  end

  assign waddr        = wbin_r[ADDRSIZE-1:0];
  assign wptr         = wptr_r;
  assign wfull        = wfull_r;
  assign walmost_full = walmost_full_r;
  assign wlevel       = wlevel_r;
  assign wovf         = wovf_r;

endmodule
